moore_seq_ctrl: RTL and testbench

- Sequencer for the 8-state Moore FSM (3-bit state, 2-bit output code).
- Takes a programmed bit-serial input pattern and puts the FSM into a known state by pulsing its reset.
- Drives the FSM's 1-bit input one pattern bit per cycle, watches the FSM's output code and state, and reports the first step at which the output equals a target code.
- Sits between a register/host interface and the FSM instance as its sole stimulus source.

---
 rtl/moore_pkg.sv | 52 +++++
 rtl/moore_seq_ctrl_if.sv | 26 ++
 rtl/moore_pat_shifter.sv | 34 +++
 rtl/moore_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_moore_seq_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/moore_pkg.sv
// Shared encodings for the 8-state Moore FSM and its sequencer: FSM states,
// output codes, controller states and error-bit positions.
package moore_pkg;

    localparam logic [2:0] ST0 = 3'b000;
    localparam logic [2:0] ST1 = 3'b001;
    localparam logic [2:0] ST2 = 3'b010;
    localparam logic [2:0] ST3 = 3'b011;
    localparam logic [2:0] ST4 = 3'b100;
    localparam logic [2:0] ST5 = 3'b101;
    localparam logic [2:0] ST6 = 3'b110;
    localparam logic [2:0] ST7 = 3'b111;
    localparam logic [2:0] ST_LOCK = ST1;

    localparam logic [1:0] OUT0 = 2'b00;
    localparam logic [1:0] OUT1 = 2'b00;
    localparam logic [1:0] OUT2 = 2'b01;
    localparam logic [1:0] OUT3 = 2'b01;
    localparam logic [1:0] OUT4 = 2'b01;
    localparam logic [1:0] OUT5 = 2'b11;
    localparam logic [1:0] OUT6 = 2'b10;
    localparam logic [1:0] OUT7 = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        CHECK0,
        DRIVE,
        CMP_LAST,
        DONE
    } ctrl_state_t;

    localparam int ERR_NORST = 0;
    localparam int ERR_LOCK  = 1;

    function automatic logic [1:0] out_code(input logic [2:0] st);
        logic [1:0] code;
        case (st)
            ST0:     code = OUT0;
            ST1:     code = OUT1;
            ST2:     code = OUT2;
            ST3:     code = OUT3;
            ST4:     code = OUT4;
            ST5:     code = OUT5;
            ST6:     code = OUT6;
            default: code = OUT7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/moore_seq_ctrl_if.sv
// Host-side request/result bus of the Moore FSM sequencer.
interface moore_seq_ctrl_if #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [1:0]       target;
    logic             busy;
    logic             done;
    logic             hit;
    logic [LEN_W-1:0] hit_step;
    logic [2:0]       final_st;
    logic [1:0]       err;

    modport master (
        output start, pattern, length, target,
        input  busy, done, hit, hit_step, final_st, err
    );

    modport slave (
        input  start, pattern, length, target,
        output busy, done, hit, hit_step, final_st, err
    );
endinterface

// File: rtl/moore_pat_shifter.sv
// Holds the captured stimulus pattern; presents the next bit to drive, its
// step index and whether it is the final step of the run.
module moore_pat_shifter #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             load,
    input  logic             advance,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    output logic             bit_cur,
    output logic [LEN_W-1:0] idx,
    output logic             last,
    output logic             empty
);
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (load) begin
            pat_q <= pattern;
            len_q <= length;
            idx   <= '0;
        end else if (advance) begin
            pat_q <= pat_q >> 1;
            idx   <= idx + LEN_W'(1);
        end
    end

    assign bit_cur = pat_q[0];
    assign last    = (idx == len_q - LEN_W'(1));
    assign empty   = (len_q == '0);
endmodule

// File: rtl/moore_seq_ctrl.sv
// Sequencer that resets the Moore FSM, drives a bit-serial pattern into it and
// reports the first step whose output code matches the target.
// Optional lock abort when MOORE_LOCK_ABORT_EN is defined.
module moore_seq_ctrl
    import moore_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    moore_seq_ctrl_if.slave      bus,
    input  logic [1:0]           fsm_b_out,
    input  logic [2:0]           fsm_st,
    output logic                 fsm_reset,
    output logic                 fsm_a_in
);
    ctrl_state_t      state;
    logic [1:0]       tgt_q;
    logic [LEN_W-1:0] step_p0, step_p1;
    logic             last_p0, vld_p1;
    logic             busy_q, done_q, hit_q;
    logic [LEN_W-1:0] hit_step_q;
    logic [2:0]       final_st_q;
    logic [1:0]       err_q;

    logic             bit_cur, last, empty;
    logic [LEN_W-1:0] idx;
    logic             load, advance, match_p1, lock_hit, finish;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    endfunction

    moore_pat_shifter #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift (
        .clk     (clk),
        .load    (load),
        .advance (advance),
        .pattern (bus.pattern),
        .length  (clamp_len(bus.length)),
        .bit_cur (bit_cur),
        .idx     (idx),
        .last    (last),
        .empty   (empty)
    );

`ifdef MOORE_LOCK_ABORT_EN
    assign lock_hit = vld_p1 && (fsm_st == ST_LOCK);
`else
    assign lock_hit = 1'b0;
`endif

    assign load     = (state == IDLE) && bus.start;
    assign match_p1 = vld_p1 && !hit_q && (fsm_b_out == tgt_q);
    assign advance  = ((state == SETTLE) && (fsm_st == ST0) && !empty)
                   || ((state == DRIVE) && !last_p0 && !lock_hit);
    // A failed FSM reset still occupies the CHECK0 slot so it completes on the same cycle as an empty run.
    assign finish   = (state == CHECK0) || (state == CMP_LAST)
                   || ((state == DRIVE) && lock_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            fsm_reset  <= 1'b1;
            fsm_a_in   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            hit_step_q <= '0;
            final_st_q <= '0;
            err_q      <= '0;
            vld_p1     <= 1'b0;
            last_p0    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    fsm_reset <= 1'b0;
                    if (bus.start) begin
                        tgt_q      <= bus.target;
                        hit_q      <= 1'b0;
                        hit_step_q <= '0;
                        err_q      <= '0;
                        busy_q     <= 1'b1;
                        fsm_reset  <= 1'b1;
                        state      <= RST;
                    end
                end
                RST: begin
                    fsm_reset <= 1'b0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    vld_p1 <= 1'b0;
                    if (fsm_st != ST0) begin
                        err_q[ERR_NORST] <= 1'b1;
                        state            <= CHECK0;
                    end else if (empty) begin
                        state <= CHECK0;
                    end else begin
                        fsm_a_in <= bit_cur;
                        step_p0  <= idx;
                        last_p0  <= last;
                        state    <= DRIVE;
                    end
                end
                CHECK0: begin
                    if (!err_q[ERR_NORST] && (fsm_b_out == tgt_q))
                        hit_q <= 1'b1;
                end
                // drive stage p0 feeds step k; compare stage p1 checks step k-1
                DRIVE: begin
                    if (match_p1) begin
                        hit_q      <= 1'b1;
                        hit_step_q <= step_p1;
                    end
                    step_p1 <= step_p0;
                    vld_p1  <= 1'b1;
                    if (last_p0) begin
                        fsm_a_in <= 1'b0;
                        state    <= CMP_LAST;
                    end else begin
                        fsm_a_in <= bit_cur;
                        step_p0  <= idx;
                        last_p0  <= last;
                    end
                end
                CMP_LAST: begin
                    if (match_p1) begin
                        hit_q      <= 1'b1;
                        hit_step_q <= step_p1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (lock_hit && ((state == DRIVE) || (state == CMP_LAST)))
                err_q[ERR_LOCK] <= 1'b1;

            if (finish) begin
                state      <= DONE;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                final_st_q <= fsm_st;
                fsm_a_in   <= 1'b0;
                vld_p1     <= 1'b0;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit      = hit_q;
    assign bus.hit_step = hit_step_q;
    assign bus.final_st = final_st_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl with a behavioural 8-state Moore FSM that
// steps only while the bench's step window is open.
`timescale 1ns/1ps
module tb_moore_seq_ctrl;
    localparam int PAT_W = 16;
    localparam int LEN_W = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] fsm_b_out;
    logic [2:0] fsm_st = 3'b000;
    logic       fsm_reset, fsm_a_in;
    logic       fsm_en = 1'b0;
    logic       stuck = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    moore_seq_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) bus ();

    moore_seq_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_b_out (fsm_b_out),
        .fsm_st    (fsm_st),
        .fsm_reset (fsm_reset),
        .fsm_a_in  (fsm_a_in)
    );

    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic a);
        case (s)
            3'd0: return a ? 3'd2 : 3'd4;
            3'd1: return 3'd1;
            3'd2: return a ? 3'd7 : 3'd3;
            3'd3: return a ? 3'd5 : 3'd0;
            3'd4: return a ? 3'd1 : 3'd6;
            3'd5: return a ? 3'd0 : 3'd5;
            3'd6: return a ? 3'd2 : 3'd5;
            default: return a ? 3'd6 : 3'd5;
        endcase
    endfunction

    function automatic logic [1:0] fsm_out(input logic [2:0] s);
        case (s)
            3'd0, 3'd1:       return 2'b00;
            3'd2, 3'd3, 3'd4: return 2'b01;
            3'd5:             return 2'b11;
            3'd6:             return 2'b10;
            default:          return 2'b01;
        endcase
    endfunction

    always @(posedge clk) begin
        if (stuck)          fsm_st <= 3'd3;
        else if (fsm_reset) fsm_st <= 3'd0;
        else if (fsm_en)    fsm_st <= fsm_next(fsm_st, fsm_a_in);
    end
    assign fsm_b_out = fsm_out(fsm_st);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".fsm_reset"}, 32'(fsm_reset), 32'd1);
        check({tag, ".fsm_a_in"},  32'(fsm_a_in),  32'd0);
        check({tag, ".busy"},      32'(bus.busy),  32'd0);
        check({tag, ".done"},      32'(bus.done),  32'd0);
        check({tag, ".hit"},       32'(bus.hit),   32'd0);
        check({tag, ".hit_step"},  32'(bus.hit_step), 32'd0);
        check({tag, ".final_st"},  32'(bus.final_st), 32'd0);
        check({tag, ".err"},       32'(bus.err),   32'd0);
    endtask

    // Cycle c is the c-th clock after the edge that accepts start.
    task automatic run(input string nm, input logic [15:0] pat, input logic [4:0] len,
                       input logic [1:0] tgt, input bit inject, input int exp_cyc,
                       input logic exp_hit, input logic [4:0] exp_step,
                       input logic [2:0] exp_fst, input logic [1:0] exp_err);
        int steps;
        int got;
        steps = (len > 5'd16) ? 16 : int'(len);
        got = -1;
        @(negedge clk);
        bus.pattern = pat;
        bus.length  = len;
        bus.target  = tgt;
        bus.start   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = inject && (c == 3);
            if (inject && c == 3) begin
                bus.pattern = 16'h0000;
                bus.target  = 2'b10;
            end
            fsm_en = (c >= 3) && (c <= steps + 2);
            if (c == 1) check({nm, ".busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                got = c;
                break;
            end
        end
        fsm_en = 1'b0;
        bus.start = 1'b0;
        check({nm, ".done_cycle"}, 32'(got), 32'(exp_cyc));
        check({nm, ".hit"},        32'(bus.hit),      32'(exp_hit));
        check({nm, ".hit_step"},   32'(bus.hit_step), 32'(exp_step));
        check({nm, ".final_st"},   32'(bus.final_st), 32'(exp_fst));
        check({nm, ".err"},        32'(bus.err),      32'(exp_err));
        @(negedge clk);
        check({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({nm, ".idle_busy"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic done_seen;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.length  = '0;
        bus.target  = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("por.fsm_reset_release", 32'(fsm_reset), 32'd0);

        run("p3_t11",   16'h0003, 5'd3,  2'b11, 1'b0, 7, 1'b1, 5'd2, 3'd5, 2'b00);
        run("p0_t10",   16'h0000, 5'd3,  2'b10, 1'b0, 7, 1'b1, 5'd1, 3'd5, 2'b00);
        run("p1_first", 16'h0001, 5'd3,  2'b01, 1'b0, 7, 1'b1, 5'd0, 3'd0, 2'b00);
`ifdef MOORE_LOCK_ABORT_EN
        run("lock",     16'h0002, 5'd8,  2'b11, 1'b0, 6, 1'b0, 5'd0, 3'd1, 2'b10);
`else
        run("lock",     16'h0002, 5'd8,  2'b11, 1'b0, 12, 1'b0, 5'd0, 3'd1, 2'b00);
`endif
        run("len0_t00", 16'h0000, 5'd0,  2'b00, 1'b0, 4, 1'b1, 5'd0, 3'd0, 2'b00);
        run("len0_t01", 16'h0000, 5'd0,  2'b01, 1'b0, 4, 1'b0, 5'd0, 3'd0, 2'b00);
        run("clamp",    16'h0000, 5'd31, 2'b10, 1'b0, 20, 1'b1, 5'd1, 3'd5, 2'b00);
        run("restart",  16'h0003, 5'd3,  2'b11, 1'b1, 7, 1'b1, 5'd2, 3'd5, 2'b00);

        stuck = 1'b1;
        run("stuck",    16'h0000, 5'd4,  2'b00, 1'b0, 4, 1'b0, 5'd0, 3'd3, 2'b01);
        stuck = 1'b0;

        // reset sampled at the end of cycle 6 of a 16-step run
        @(negedge clk);
        bus.pattern = 16'hFFFF;
        bus.length  = 5'd16;
        bus.target  = 2'b11;
        bus.start   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            fsm_en = (c >= 3);
            if (c == 6) reset = 1'b0;
        end
        @(negedge clk);
        fsm_en = 1'b0;
        check_reset_vals("midrst");
        @(negedge clk);
        check("midrst.fsm_reset_hold", 32'(fsm_reset), 32'd1);
        reset = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("midrst.no_done", 32'(done_seen), 32'd0);
        check("midrst.fsm_reset_low", 32'(fsm_reset), 32'd0);

        run("after_rst", 16'h0000, 5'd3, 2'b10, 1'b0, 7, 1'b1, 5'd1, 3'd5, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
